// File: rtl/sm4_decrypt_iter.sv
// sm4_decrypt_iter: iterative SM4 block decryptor, one round per clock, round keys expanded on chip
// Ports: CLK_i/RST_N_i clock and async active-low reset; MK_i/MK_VALID_i/MK_READY_o master key load;
// KEY_READY_o round-key table valid; CT_i/CT_VALID_i/CT_READY_o ciphertext in; PT_o/PT_VALID_o plaintext out.
module sm4_decrypt_iter (
  input  logic         CLK_i,
  input  logic         RST_N_i,
  input  logic [127:0] MK_i,
  input  logic         MK_VALID_i,
  output logic         MK_READY_o,
  output logic         KEY_READY_o,
  input  logic [127:0] CT_i,
  input  logic         CT_VALID_i,
  output logic         CT_READY_o,
  output logic [127:0] PT_o,
  output logic         PT_VALID_o
);
  typedef enum logic [1:0] {IDLE, KEXP, READY, DEC} state_t;
  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [127:0] w_q, w_d, pt_q, pt_d;
  logic pt_valid_q, pt_valid_d, key_ready_q, key_ready_d;
  logic [31:0] rk_q [32];
  logic [7:0] m;
  logic [31:0] ck, t_in, s, nw;
  logic kexp, mk_hs, ct_hs;
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction
  assign MK_READY_o  = state_q == IDLE || state_q == READY;
  assign CT_READY_o  = state_q == READY && !MK_VALID_i;
  assign KEY_READY_o = key_ready_q;
  assign PT_o        = pt_q;
  assign PT_VALID_o  = pt_valid_q;
  // w_q is the key shift register during KEXP and the data shift register during DEC;
  // the two phases never overlap, so they also share one set of S-boxes.
  always_comb begin
    kexp = state_q == KEXP;
    mk_hs = MK_VALID_i && MK_READY_o;
    ct_hs = CT_VALID_i && CT_READY_o;
    m = {1'b0, cnt_q, 2'b00} * 8'd7;
    ck = {m, m + 8'd7, m + 8'd14, m + 8'd21};
    t_in = w_q[95:64] ^ w_q[63:32] ^ w_q[31:0] ^ (kexp ? ck : rk_q[~cnt_q]);
    s = tau(t_in);
    nw = w_q[127:96] ^ s ^ (kexp ? {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]}
                                 : {s[29:0], s[31:30]} ^ {s[21:0], s[31:22]} ^ {s[13:0], s[31:14]} ^ {s[7:0], s[31:8]});
    state_d = state_q;
    cnt_d = cnt_q;
    w_d = w_q;
    pt_d = pt_q;
    pt_valid_d = 1'b0;
    if (mk_hs) begin
      state_d = KEXP;
      cnt_d = '0;
      w_d = MK_i ^ FK;
    end else if (ct_hs) begin
      state_d = DEC;
      cnt_d = '0;
      w_d = CT_i;
    end else if (kexp || state_q == DEC) begin
      w_d = {w_q[95:0], nw};
      cnt_d = cnt_q + 5'd1;
      state_d = &cnt_q ? READY : state_q;
      // final round: output words in reverse order {X35,X34,X33,X32}
      if (state_q == DEC && &cnt_q) begin
        pt_d = {nw, w_q[31:0], w_q[63:32], w_q[95:64]};
        pt_valid_d = 1'b1;
      end
    end
    key_ready_d = state_d == READY || state_d == DEC;
  end
  always_ff @(posedge CLK_i or negedge RST_N_i)
    if (!RST_N_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      pt_q <= '0;
      pt_valid_q <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      pt_q <= pt_d;
      pt_valid_q <= pt_valid_d;
      key_ready_q <= key_ready_d;
    end
  // round-key table is qualified by KEY_READY_o, so it carries no reset
  always_ff @(posedge CLK_i)
    if (kexp) rk_q[cnt_q] <= nw;
endmodule

// File: tb/tb_sm4_decrypt_iter.sv
// tb_sm4_decrypt_iter: directed and round-trip checks of the iterative SM4 decryptor
module tb_sm4_decrypt_iter;
  localparam logic [127:0] K0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  logic clk = 0, rst_n = 0;
  logic [127:0] mk = '0, ct = '0, pt;
  logic mk_valid = 0, ct_valid = 0, mk_ready, key_ready, ct_ready, pt_valid;
  int total = 0, bad = 0;
  sm4_decrypt_iter dut (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .MK_VALID_i(mk_valid), .MK_READY_o(mk_ready),
    .KEY_READY_o(key_ready), .CT_i(ct), .CT_VALID_i(ct_valid), .CT_READY_o(ct_ready),
    .PT_o(pt), .PT_VALID_o(pt_valid)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction
  // reference encryptor, used only to produce ciphertexts for known plaintexts
  function automatic logic [127:0] sm4_enc(input logic [127:0] key, input logic [127:0] p);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] ck, t;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64] ^ 32'h56aa3350;
    k[2] = key[63:32] ^ 32'h677d9197;
    k[3] = key[31:0] ^ 32'hb27022dc;
    x[0] = p[127:96]; x[1] = p[95:64]; x[2] = p[63:32]; x[3] = p[31:0];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8 * j -: 8] = 8'((4 * i + j) * 7);
      t = tau(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck);
      k[i + 4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
    end
    for (int i = 0; i < 32; i++) begin
      t = tau(x[i + 1] ^ x[i + 2] ^ x[i + 3] ^ k[i + 4]);
      x[i + 4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction
  task automatic load_key(input logic [127:0] k, output int lat, output logic leak, output logic acc);
    mk = k; mk_valid = 1; #1;
    acc = mk_ready;
    @(posedge clk); #1;
    mk_valid = 0;
    lat = 0; leak = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!key_ready && mk_ready) leak = 1;
      @(posedge clk); #1;
      if (key_ready) begin lat = n; break; end
    end
  endtask
  task automatic decrypt(input logic [127:0] c, output logic [127:0] p, output int lat, output logic acc);
    ct = c; ct_valid = 1; #1;
    acc = ct_ready;
    @(posedge clk); #1;
    ct_valid = 0;
    lat = 0; p = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (pt_valid) begin lat = n; p = pt; break; end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if ({key_ready, pt_valid, mk_ready, ct_ready} !== 4'b0010) begin bad++; $display("FAIL reset_flags got=%b want=0010", {key_ready, pt_valid, mk_ready, ct_ready}); end
    total++; if (pt !== '0) begin bad++; $display("FAIL reset_pt got=%h want=0", pt); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_key_timing();
    int lat; logic leak, acc;
    load_key(K0, lat, leak, acc);
    total++; if (acc !== 1) begin bad++; $display("FAIL key_accept got=%b want=1", acc); end
    total++; if (lat != 32) begin bad++; $display("FAIL key_ready_latency got=%0d want=32", lat); end
    total++; if (leak !== 0) begin bad++; $display("FAIL mk_ready_in_kexp got=%b want=0", leak); end
    total++; if (dut.rk_q[0] !== 32'hf12186f9) begin bad++; $display("FAIL rk0 got=%h want=f12186f9", dut.rk_q[0]); end
    total++; if (dut.rk_q[31] !== 32'h9124a012) begin bad++; $display("FAIL rk31 got=%h want=9124a012", dut.rk_q[31]); end
    total++; if (ct_ready !== 1) begin bad++; $display("FAIL ct_ready_after_kexp got=%b want=1", ct_ready); end
  endtask
  task automatic test_standard();
    logic [127:0] p; int lat; logic acc;
    decrypt(C0, p, lat, acc);
    total++; if (acc !== 1) begin bad++; $display("FAIL std_accept got=%b want=1", acc); end
    total++; if (lat != 32) begin bad++; $display("FAIL std_latency got=%0d want=32", lat); end
    total++; if (p !== K0) begin bad++; $display("FAIL std_pt got=%h want=%h", p, K0); end
    total++; if (ct_ready !== 1) begin bad++; $display("FAIL std_ct_ready_with_pt got=%b want=1", ct_ready); end
    @(posedge clk); #1;
    total++; if (pt_valid !== 0) begin bad++; $display("FAIL std_pulse_width got=%b want=0", pt_valid); end
    total++; if (pt !== K0) begin bad++; $display("FAIL std_pt_hold got=%h want=%h", pt, K0); end
  endtask
  task automatic test_back_to_back();
    logic [127:0] pls [4];
    logic [127:0] cts [4];
    int sent = 0, got = 0, last = 0, extra = 0;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      pls[i] = K0 ^ (128'(i + 1) << (i * 24));
      cts[i] = sm4_enc(K0, pls[i]);
    end
    ct = cts[0]; ct_valid = 1;
    for (int cyc = 1; cyc <= 200 && got < 4; cyc++) begin
      #1;
      acc = ct_ready && ct_valid;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 4) ct = cts[sent];
        else ct_valid = 0;
      end
      if (pt_valid) begin
        total++; if (pt !== pls[got]) begin bad++; $display("FAIL b2b_pt%0d got=%h want=%h", got, pt, pls[got]); end
        if (got > 0) begin
          total++; if (cyc - last != 33) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=33", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    ct_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pt_valid) extra++;
    end
    total++; if (got != 4 || extra != 0) begin bad++; $display("FAIL b2b_count got=%0d+%0d want=4+0", got, extra); end
  endtask
  task automatic test_simultaneous();
    logic [127:0] k2 = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] p2 = 128'hdeadbeef0badf00dcafebabe13579bdf;
    logic [127:0] prev = pt, c2;
    int n_acc = 0, lat = 0;
    logic acc;
    c2 = sm4_enc(k2, p2);
    mk = k2; mk_valid = 1; ct = c2; ct_valid = 1; #1;
    total++; if (ct_ready !== 0) begin bad++; $display("FAIL sim_ct_ready got=%b want=0", ct_ready); end
    total++; if (mk_ready !== 1) begin bad++; $display("FAIL sim_mk_ready got=%b want=1", mk_ready); end
    @(posedge clk); #1;
    mk_valid = 0;
    for (int n = 1; n <= 60; n++) begin
      #1;
      acc = ct_ready;
      @(posedge clk); #1;
      if (acc) begin n_acc = n; break; end
    end
    ct_valid = 0;
    total++; if (n_acc != 33) begin bad++; $display("FAIL sim_ct_accept_edge got=%0d want=33", n_acc); end
    total++; if (pt !== prev) begin bad++; $display("FAIL sim_pt_preserved got=%h want=%h", pt, prev); end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (pt_valid) begin lat = n; break; end
    end
    total++; if (lat != 32 || pt !== p2) begin bad++; $display("FAIL sim_pt got=%h/%0d want=%h/32", pt, lat, p2); end
  endtask
  task automatic test_reset_mid_dec();
    logic flag = 0;
    ct = sm4_enc(128'h00112233445566778899aabbccddeeff, 128'h1); ct_valid = 1; #1;
    @(posedge clk); #1;
    ct_valid = 0;
    repeat (15) @(posedge clk);
    #1; rst_n = 0; #1;
    total++; if ({key_ready, pt_valid, mk_ready, ct_ready} !== 4'b0010) begin bad++; $display("FAIL rst_mid_flags got=%b want=0010", {key_ready, pt_valid, mk_ready, ct_ready}); end
    total++; if (pt !== '0) begin bad++; $display("FAIL rst_mid_pt got=%h want=0", pt); end
    @(negedge clk) rst_n = 1;
    ct_valid = 1;
    repeat (40) begin
      #1;
      if (ct_ready || pt_valid || key_ready) flag = 1;
      @(posedge clk); #1;
    end
    ct_valid = 0;
    total++; if (flag !== 0) begin bad++; $display("FAIL rst_no_key_accept got=%b want=0", flag); end
  endtask
  task automatic test_round_trip();
    logic [127:0] k, p, c, got;
    int lat; logic leak, acc, acc2;
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = sm4_enc(k, p);
      load_key(k, lat, leak, acc);
      decrypt(c, got, lat, acc2);
      total++; if (got !== p || !acc || !acc2) begin bad++; $display("FAIL round_trip%0d got=%h want=%h", i, got, p); end
    end
  endtask
  initial begin
    test_reset();
    test_key_timing();
    test_standard();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_dec();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
